// File: rtl/robo_sensor_scan_if.sv
// Map memory read port shared by the sensor scanner and the map memory.
interface robo_sensor_scan_if #(
  parameter int unsigned ROW_W  = 5,
  parameter int unsigned COL_W  = 6,
  parameter int unsigned CELL_W = 2
);
  logic              rd_en;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic [CELL_W-1:0] rd_data;

  // scanner side issues addresses, memory side returns the cell one cycle later
  modport master (output rd_en, output rd_row, output rd_col, input rd_data);
  modport slave  (input rd_en, input rd_row, input rd_col, output rd_data);
endinterface

// File: rtl/robo_sensor_scan.sv
// Sensor stage: reads the cells ahead, left and under the robot through one
// synchronous map read port and produces registered head/left/under/barrier flags.
module robo_sensor_scan #(
  parameter int unsigned ROWS         = 10,
  parameter int unsigned COLS         = 20,
  parameter int unsigned ROW_W        = 5,
  parameter int unsigned COL_W        = 6,
  parameter int unsigned CELL_W       = 2,
  parameter int unsigned CELL_WALL    = 1,
  parameter int unsigned CELL_BARRIER = 2,
  parameter int unsigned CELL_EXIT    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ROW_W-1:0]          robo_row,
  input  logic [COL_W-1:0]          robo_col,
  input  logic [1:0]                robo_orientacao,
  robo_sensor_scan_if.master        map,
  output logic                      busy,
  output logic                      valid,
  output logic                      head,
  output logic                      left,
  output logic                      under,
  output logic                      barrier
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_HEAD  = 3'd1,
    RD_LEFT  = 3'd2,
    RD_UNDER = 3'd3,
    WAIT     = 3'd4,
    DONE     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [1:0]        ori_q, ori_d;
  logic [CELL_W-1:0] ahead_cell_q, ahead_cell_d;
  logic [CELL_W-1:0] left_cell_q, left_cell_d;
  logic              rd_en_q, rd_en_d;
  logic [ROW_W-1:0]  rd_row_q, rd_row_d;
  logic [COL_W-1:0]  rd_col_q, rd_col_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              head_q, head_d;
  logic              left_q, left_d;
  logic              under_q, under_d;
  logic              barrier_q, barrier_d;

  // position the current slot refers to: live inputs while idle, latched copy afterwards
  logic [ROW_W-1:0]  base_row;
  logic [COL_W-1:0]  base_col;
  logic [1:0]        base_ori;
  logic [1:0]        left_ori;
  logic              in_map;
  logic              ahead_off;
  logic              left_off;

  // neighbour in direction o falls off the map edge (checked before any arithmetic)
  function automatic logic nb_off(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c,
                                  input logic [1:0] o);
    logic off;
    case (o)
      2'd0:    off = (r == '0);
      2'd1:    off = (c == COL_W'(COLS - 1));
      2'd2:    off = (r == ROW_W'(ROWS - 1));
      default: off = (c == '0);
    endcase
    return off;
  endfunction

  function automatic logic [ROW_W-1:0] nb_row(input logic [ROW_W-1:0] r, input logic [1:0] o);
    logic [ROW_W-1:0] nr;
    case (o)
      2'd0:    nr = r - ROW_W'(1);
      2'd2:    nr = r + ROW_W'(1);
      default: nr = r;
    endcase
    return nr;
  endfunction

  function automatic logic [COL_W-1:0] nb_col(input logic [COL_W-1:0] c, input logic [1:0] o);
    logic [COL_W-1:0] nc;
    case (o)
      2'd1:    nc = c + COL_W'(1);
      2'd3:    nc = c - COL_W'(1);
      default: nc = c;
    endcase
    return nc;
  endfunction

  // next-state, read-slot addressing and flag evaluation
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    ori_d        = ori_q;
    ahead_cell_d = ahead_cell_q;
    left_cell_d  = left_cell_q;
    rd_en_d      = 1'b0;
    rd_row_d     = rd_row_q;
    rd_col_d     = rd_col_q;
    valid_d      = 1'b0;
    head_d       = head_q;
    left_d       = left_q;
    under_d      = under_q;
    barrier_d    = barrier_q;

    base_row  = (state_q == IDLE) ? robo_row        : row_q;
    base_col  = (state_q == IDLE) ? robo_col        : col_q;
    base_ori  = (state_q == IDLE) ? robo_orientacao : ori_q;
    left_ori  = base_ori + 2'd3;
    in_map    = (base_row < ROW_W'(ROWS)) && (base_col < COL_W'(COLS));
    ahead_off = nb_off(base_row, base_col, base_ori);
    left_off  = nb_off(base_row, base_col, left_ori);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_HEAD;
          row_d   = robo_row;
          col_d   = robo_col;
          ori_d   = robo_orientacao;
          if (in_map && !ahead_off) begin
            rd_en_d  = 1'b1;
            rd_row_d = nb_row(base_row, base_ori);
            rd_col_d = nb_col(base_col, base_ori);
          end
        end
      end
      RD_HEAD: begin
        state_d = RD_LEFT;
        if (in_map && !left_off) begin
          rd_en_d  = 1'b1;
          rd_row_d = nb_row(base_row, left_ori);
          rd_col_d = nb_col(base_col, left_ori);
        end
      end
      RD_LEFT: begin
        state_d      = RD_UNDER;
        ahead_cell_d = (in_map && !ahead_off) ? map.rd_data : CELL_W'(CELL_WALL);
        if (in_map) begin
          rd_en_d  = 1'b1;
          rd_row_d = base_row;
          rd_col_d = base_col;
        end
      end
      RD_UNDER: begin
        state_d     = WAIT;
        left_cell_d = (in_map && !left_off) ? map.rd_data : CELL_W'(CELL_WALL);
      end
      WAIT: begin
        state_d   = DONE;
        valid_d   = 1'b1;
        head_d    = (ahead_cell_q == CELL_W'(CELL_WALL));
        barrier_d = (ahead_cell_q == CELL_W'(CELL_BARRIER));
        left_d    = (left_cell_q == CELL_W'(CELL_WALL));
        under_d   = in_map && (map.rd_data == CELL_W'(CELL_EXIT));
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      ori_q        <= '0;
      ahead_cell_q <= '0;
      left_cell_q  <= '0;
      rd_en_q      <= 1'b0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      head_q       <= 1'b0;
      left_q       <= 1'b0;
      under_q      <= 1'b0;
      barrier_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      ori_q        <= ori_d;
      ahead_cell_q <= ahead_cell_d;
      left_cell_q  <= left_cell_d;
      rd_en_q      <= rd_en_d;
      rd_row_q     <= rd_row_d;
      rd_col_q     <= rd_col_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      head_q       <= head_d;
      left_q       <= left_d;
      under_q      <= under_d;
      barrier_q    <= barrier_d;
    end
  end

  assign map.rd_en  = rd_en_q;
  assign map.rd_row = rd_row_q;
  assign map.rd_col = rd_col_q;
  assign busy       = busy_q;
  assign valid      = valid_q;
  assign head       = head_q;
  assign left       = left_q;
  assign under      = under_q;
  assign barrier    = barrier_q;

endmodule

// File: tb/tb_robo_sensor_scan.sv
// Directed bench for robo_sensor_scan with a small map memory model.
module tb_robo_sensor_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] robo_row;
  logic [5:0] robo_col;
  logic [1:0] robo_orientacao;
  logic       busy, valid, head, left, under, barrier;

  logic [1:0]  mem [0:9][0:19];
  logic [10:0] rd_log [$];
  int          valid_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  robo_sensor_scan_if #(.ROW_W(5), .COL_W(6), .CELL_W(2)) map_if ();

  robo_sensor_scan dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .robo_row        (robo_row),
    .robo_col        (robo_col),
    .robo_orientacao (robo_orientacao),
    .map             (map_if),
    .busy            (busy),
    .valid           (valid),
    .head            (head),
    .left            (left),
    .under           (under),
    .barrier         (barrier)
  );

  always #5 clk = ~clk;

  // map memory: one-cycle read latency, logs every issued address
  always @(posedge clk) begin
    if (map_if.rd_en) begin
      rd_log.push_back({map_if.rd_row, map_if.rd_col});
      if (int'(map_if.rd_row) < 10 && int'(map_if.rd_col) < 20)
        map_if.rd_data <= mem[int'(map_if.rd_row)][int'(map_if.rd_col)];
      else
        map_if.rd_data <= 2'd0;
    end
  end

  // valid pulse counter
  always @(posedge clk) begin
    if (valid) valid_cnt <= valid_cnt + 1;
  end

  function automatic logic [10:0] addr(input int r, input int c);
    return {5'(r), 6'(c)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // full scan from idle with read-address and flag checks; fl = {head,left,under,barrier}
  task automatic do_scan(input string tag, input int r, input int c, input int o,
                         input int nrd, input logic [10:0] a0, input logic [10:0] a1,
                         input logic [10:0] a2, input logic [3:0] fl);
    logic [10:0] exp_a [3];
    exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2;
    rd_log.delete();
    robo_row = 5'(r); robo_col = 6'(c); robo_orientacao = 2'(o);
    start = 1'b1;
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    chk({tag, " busy_e0"}, 32'(busy), 32'd1);
    repeat (3) @(posedge clk); #1;            // E3
    chk({tag, " valid_e3"}, 32'(valid), 32'd0);
    @(posedge clk); #1;                       // E4
    chk({tag, " valid_e4"}, 32'(valid), 32'd1);
    chk({tag, " flags"}, 32'({head, left, under, barrier}), 32'(fl));
    @(posedge clk); #1;                       // E5
    chk({tag, " valid_e5"}, 32'(valid), 32'd0);
    chk({tag, " busy_e5"}, 32'(busy), 32'd0);
    chk({tag, " nreads"}, 32'(rd_log.size()), 32'(nrd));
    for (int i = 0; i < nrd; i++)
      if (i < rd_log.size()) chk($sformatf("%s rd%0d", tag, i), 32'(rd_log[i]), 32'(exp_a[i]));
  endtask

  initial begin
    int  v0;
    bit  ok;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 20; c++)
        mem[r][c] = 2'd0;
    mem[4][8] = 2'd1;
    mem[6][5] = 2'd2;
    mem[5][6] = 2'd1;
    mem[5][5] = 2'd3;
    mem[9][0] = 2'd3;

    // reset held with start asserted
    reset = 1'b0; start = 1'b1;
    robo_row = 5'd4; robo_col = 6'd7; robo_orientacao = 2'd1;
    repeat (2) @(posedge clk); #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst flags", 32'({head, left, under, barrier}), 32'd0);
    chk("rst rd_en", 32'(map_if.rd_en), 32'd0);
    chk("rst rd_addr", 32'({map_if.rd_row, map_if.rd_col}), 32'd0);
    start = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk("post rst busy", 32'(busy), 32'd0);

    // interior, east, wall ahead
    do_scan("interior", 4, 7, 1, 3, addr(4, 8), addr(3, 7), addr(4, 7), 4'b1000);
    // south, barrier ahead, wall left, exit under
    do_scan("barrier", 5, 5, 2, 3, addr(6, 5), addr(5, 6), addr(5, 5), 4'b0111);
    // north edge: ahead off-map, left read (0,18)
    do_scan("edge_n", 0, 19, 0, 2, addr(0, 18), addr(0, 19), 11'd0, 4'b1000);
    // corner facing west: ahead and left off-map, only under read
    do_scan("edge_w", 9, 0, 3, 1, addr(9, 0), 11'd0, 11'd0, 4'b1110);
    // position outside map: no reads
    do_scan("offmap", 10, 3, 0, 0, 11'd0, 11'd0, 11'd0, 4'b1100);
    // exit ahead is neither head nor barrier
    do_scan("exit_ahead", 5, 4, 1, 3, addr(5, 5), addr(4, 4), addr(5, 4), 4'b0000);

    // start pulsed at E2 with a new position is ignored; inputs change mid-scan
    rd_log.delete();
    robo_row = 5'd4; robo_col = 6'd7; robo_orientacao = 2'd1; start = 1'b1;
    @(posedge clk); #1;                       // E0
    start = 1'b0; v0 = valid_cnt;
    @(posedge clk); #1;                       // E1
    robo_row = 5'd5; robo_col = 6'd5; robo_orientacao = 2'd2; start = 1'b1;
    @(posedge clk); #1;                       // E2
    start = 1'b0;
    repeat (4) @(posedge clk); #1;            // E6
    repeat (4) @(posedge clk); #1;
    chk("busy_ign pulses", 32'(valid_cnt - v0), 32'd1);
    chk("busy_ign flags", 32'({head, left, under, barrier}), 32'b1000);
    chk("busy_ign nreads", 32'(rd_log.size()), 32'd3);
    if (rd_log.size() > 1) chk("busy_ign left addr", 32'(rd_log[1]), 32'(addr(3, 7)));

    // start held high through DONE is accepted once the scan completes
    robo_row = 5'd4; robo_col = 6'd7; robo_orientacao = 2'd1; start = 1'b1;
    @(posedge clk); #1;                       // E0
    robo_row = 5'd5; robo_col = 6'd5; robo_orientacao = 2'd2;
    repeat (4) @(posedge clk); #1;            // E4
    chk("held first valid", 32'(valid), 32'd1);
    chk("held first flags", 32'({head, left, under, barrier}), 32'b1000);
    repeat (2) @(posedge clk); #1;            // E6
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      if (valid) ok = 1'b1;
    end
    chk("held second accepted", 32'(ok), 32'd1);
    chk("held second flags", 32'({head, left, under, barrier}), 32'b0111);
    repeat (3) @(posedge clk); #1;
    chk("held idle", 32'(busy), 32'd0);

    // reset while in RD_LEFT aborts the scan
    robo_row = 5'd4; robo_col = 6'd7; robo_orientacao = 2'd1; start = 1'b1;
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    @(posedge clk); #1;                       // E1, state RD_LEFT
    reset = 1'b0;
    @(posedge clk); #1;                       // E2
    chk("midrst flags", 32'({head, left, under, barrier}), 32'd0);
    chk("midrst valid", 32'(valid), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst rd_en", 32'(map_if.rd_en), 32'd0);
    reset = 1'b1;
    v0 = valid_cnt;
    repeat (6) @(posedge clk); #1;
    chk("midrst no pulse", 32'(valid_cnt - v0), 32'd0);
    do_scan("after_rst", 5, 5, 2, 3, addr(6, 5), addr(5, 6), addr(5, 5), 4'b0111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
